// File: rtl/butterfly_digit_router_pkg.sv
// Shared types and helpers for the butterfly digit router: digit width,
// destination-tag digit extraction and credit counter sizing.
package butterfly_digit_router_pkg;

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_BODY = 1'b1
    } in_state_e;

    function automatic int unsigned digit_width(input int unsigned k);
        return (k > 1) ? 32'($clog2(k)) : 32'd1;
    endfunction

    function automatic int unsigned credit_width(input int unsigned depth);
        return 32'($clog2(depth + 1));
    endfunction

    // MSB digit selects the output at stage 0
    function automatic int unsigned route_digit(input logic [63:0] dest,
                                                input int unsigned stage,
                                                input int unsigned n,
                                                input int unsigned dw);
        logic [63:0] sel;
        sel = (dest >> ((n - 1 - stage) * dw)) & ((64'd1 << dw) - 64'd1);
        return 32'(sel);
    endfunction

endpackage

// File: rtl/butterfly_digit_router_if.sv
// Link bundle of a radix-K router: K input links and K output links.
interface butterfly_digit_router_if #(
    parameter int unsigned K          = 2,
    parameter int unsigned DEST_WIDTH = 6,
    parameter int unsigned FLIT_WIDTH = 128
);
    logic [K-1:0][FLIT_WIDTH-1:0] data_in;
    logic [K-1:0][DEST_WIDTH-1:0] dest_in;
    logic [K-1:0]                 is_tail_in;
    logic [K-1:0]                 send_in;
    logic [K-1:0]                 credit_out;
    logic [K-1:0][FLIT_WIDTH-1:0] data_out;
    logic [K-1:0][DEST_WIDTH-1:0] dest_out;
    logic [K-1:0]                 is_tail_out;
    logic [K-1:0]                 send_out;
    logic [K-1:0]                 credit_in;

    modport master (
        output data_in, dest_in, is_tail_in, send_in, credit_in,
        input  credit_out, data_out, dest_out, is_tail_out, send_out
    );

    modport slave (
        input  data_in, dest_in, is_tail_in, send_in, credit_in,
        output credit_out, data_out, dest_out, is_tail_out, send_out
    );
endinterface

// File: rtl/butterfly_digit_router_rr_arbiter.sv
// K-way round-robin arbiter; the pointer moves past the last grantee only on adv.
module butterfly_digit_router_rr_arbiter
    import butterfly_digit_router_pkg::*;
#(
    parameter  int unsigned K  = 2,
    localparam int unsigned DW = digit_width(K)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [K-1:0]  req,
    input  logic          adv,
    input  logic [DW-1:0] adv_idx,
    output logic          gnt_valid_c,
    output logic [DW-1:0] gnt_idx_c
);
    logic [DW-1:0] ptr;
    logic [DW-1:0] scan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= adv_idx + DW'(1);
        end
    end

    // first requester at or after the pointer wins
    always_comb begin
        gnt_valid_c = 1'b0;
        gnt_idx_c   = '0;
        scan        = '0;
        for (int k = 0; k < K; k++) begin
            scan = ptr + DW'(k);
            if (!gnt_valid_c && req[scan]) begin
                gnt_valid_c = 1'b1;
                gnt_idx_c   = scan;
            end
        end
    end
endmodule

// File: rtl/butterfly_digit_router.sv
// Radix-K butterfly switch element: per-input flit FIFOs, destination-digit
// routing, wormhole output locks, round-robin arbitration and credit flow control.
module butterfly_digit_router
    import butterfly_digit_router_pkg::*;
#(
    parameter int unsigned K                 = 2,
    parameter int unsigned N                 = 2,
    parameter int unsigned STAGE             = 0,
    parameter int unsigned DEST_WIDTH        = 6,
    parameter int unsigned FLIT_WIDTH        = 128,
    parameter int unsigned FLIT_BUFFER_DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    butterfly_digit_router_if.slave bus
);
    localparam int unsigned DW = digit_width(K);
    localparam int unsigned CW = credit_width(FLIT_BUFFER_DEPTH);
    localparam int unsigned PW = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST  = PW'(FLIT_BUFFER_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FLIT_BUFFER_DEPTH);

    logic [FLIT_WIDTH-1:0] mem_data [K][FLIT_BUFFER_DEPTH];
    logic [DEST_WIDTH-1:0] mem_dest [K][FLIT_BUFFER_DEPTH];
    logic                  mem_tail [K][FLIT_BUFFER_DEPTH];
    logic [K-1:0][PW-1:0]  wr_ptr, rd_ptr;
    logic [K-1:0][CW-1:0]  fill;
    logic [K-1:0]          wr_en, deq, full, head_valid, head_tail, idle;
    logic [FLIT_WIDTH-1:0] head_data [K];
    logic [DEST_WIDTH-1:0] head_dest [K];
    logic [K-1:0][DW-1:0]  head_digit, route, route_q;
    in_state_e             in_state    [K];
    in_state_e             in_state_nx [K];

    logic [K-1:0][K-1:0]   arb_req;
    logic [K-1:0]          arb_valid, lock_valid, gnt_valid, can_send, adv;
    logic [K-1:0][DW-1:0]  arb_idx, lock_owner, gnt_idx;
    logic [K-1:0][CW-1:0]  credits;

    logic [K-1:0][FLIT_WIDTH-1:0] data_q;
    logic [K-1:0][DEST_WIDTH-1:0] dest_q;
    logic [K-1:0]                 tail_q, send_q, credit_q;

    always_comb begin
        for (int i = 0; i < K; i++) begin
            full[i]       = (fill[i] == DEPTH_CNT);
            wr_en[i]      = bus.send_in[i] && !full[i];
            head_valid[i] = (fill[i] != '0);
            head_data[i]  = mem_data[i][rd_ptr[i]];
            head_dest[i]  = mem_dest[i][rd_ptr[i]];
            head_tail[i]  = mem_tail[i][rd_ptr[i]];
            head_digit[i] = DW'(route_digit(64'(head_dest[i]), STAGE, N, DW));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < K; i++) begin
            if (wr_en[i]) begin
                mem_data[i][wr_ptr[i]] <= bus.data_in[i];
                mem_dest[i][wr_ptr[i]] <= bus.dest_in[i];
                mem_tail[i][wr_ptr[i]] <= bus.is_tail_in[i];
            end
        end
    end

    // writes to a full FIFO are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            for (int i = 0; i < K; i++) begin
                if (wr_en[i]) wr_ptr[i] <= (wr_ptr[i] == PTR_LAST) ? '0 : wr_ptr[i] + PW'(1);
                if (deq[i])   rd_ptr[i] <= (rd_ptr[i] == PTR_LAST) ? '0 : rd_ptr[i] + PW'(1);
                fill[i] <= fill[i] + CW'(wr_en[i]) - CW'(deq[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) in_state[i] <= IN_IDLE;
        end else begin
            for (int i = 0; i < K; i++) in_state[i] <= in_state_nx[i];
        end
    end

    always_comb begin
        for (int i = 0; i < K; i++) begin
            in_state_nx[i] = in_state[i];
            if (deq[i]) in_state_nx[i] = head_tail[i] ? IN_IDLE : IN_BODY;
        end
    end

    // body flits follow the route latched from their head
    always_comb begin
        for (int i = 0; i < K; i++) begin
            idle[i]  = (in_state[i] == IN_IDLE);
            route[i] = idle[i] ? head_digit[i] : route_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            route_q <= '0;
        end else begin
            for (int i = 0; i < K; i++) begin
                if (deq[i] && idle[i]) route_q[i] <= head_digit[i];
            end
        end
    end

    always_comb begin
        arb_req = '0;
        for (int o = 0; o < K; o++) begin
            for (int i = 0; i < K; i++) begin
                arb_req[o][i] = head_valid[i] && idle[i] && (route[i] == DW'(o));
            end
        end
    end

    for (genvar o = 0; o < K; o++) begin : g_arb
        butterfly_digit_router_rr_arbiter #(.K(K)) u_arb (
            .clk         (clk),
            .rst_n       (rst_n),
            .req         (arb_req[o]),
            .adv         (adv[o]),
            .adv_idx     (gnt_idx[o]),
            .gnt_valid_c (arb_valid[o]),
            .gnt_idx_c   (arb_idx[o])
        );
    end

    // a credit arriving this cycle may be spent this cycle
    always_comb begin
        gnt_valid = '0;
        gnt_idx   = '0;
        can_send  = '0;
        adv       = '0;
        for (int o = 0; o < K; o++) begin
            can_send[o] = (credits[o] != '0) || bus.credit_in[o];
            if (lock_valid[o]) begin
                gnt_idx[o]   = lock_owner[o];
                gnt_valid[o] = can_send[o] && head_valid[lock_owner[o]];
            end else begin
                gnt_idx[o]   = arb_idx[o];
                gnt_valid[o] = can_send[o] && arb_valid[o];
            end
            adv[o] = gnt_valid[o] && head_tail[gnt_idx[o]];
        end
    end

    always_comb begin
        deq = '0;
        for (int o = 0; o < K; o++) begin
            if (gnt_valid[o]) deq[gnt_idx[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_valid <= '0;
            lock_owner <= '0;
            for (int o = 0; o < K; o++) credits[o] <= DEPTH_CNT;
        end else begin
            for (int o = 0; o < K; o++) begin
                if (gnt_valid[o]) begin
                    lock_valid[o] <= !head_tail[gnt_idx[o]];
                    lock_owner[o] <= gnt_idx[o];
                end
                case ({gnt_valid[o], bus.credit_in[o]})
                    2'b10:   credits[o] <= credits[o] - CW'(1);
                    2'b01:   credits[o] <= credits[o] + CW'(1);
                    default: credits[o] <= credits[o];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_q   <= '0;
            tail_q   <= '0;
            data_q   <= '0;
            dest_q   <= '0;
            credit_q <= '0;
        end else begin
            credit_q <= deq;
            for (int o = 0; o < K; o++) begin
                send_q[o] <= gnt_valid[o];
                tail_q[o] <= gnt_valid[o] && head_tail[gnt_idx[o]];
                data_q[o] <= gnt_valid[o] ? head_data[gnt_idx[o]] : '0;
                dest_q[o] <= gnt_valid[o] ? head_dest[gnt_idx[o]] : '0;
            end
        end
    end

    assign bus.send_out    = send_q;
    assign bus.is_tail_out = tail_q;
    assign bus.data_out    = data_q;
    assign bus.dest_out    = dest_q;
    assign bus.credit_out  = credit_q;

    for (genvar g = 0; g < K; g++) begin : g_chk
        a_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(bus.send_in[g] && full[g]));
        a_credit_overflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(bus.credit_in[g] && credits[g] == DEPTH_CNT));
    end
endmodule

// File: tb/tb_butterfly_digit_router.sv
// Directed bench for butterfly_digit_router: a K=2 stage-0 router and a
// K=4 stage-1 router, with hand-computed expected flits and credits.
module tb_butterfly_digit_router;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    logic auto_credit;
    logic [1:0] manual_credit;

    butterfly_digit_router_if #(.K(2), .DEST_WIDTH(6), .FLIT_WIDTH(128)) bus_a ();
    butterfly_digit_router_if #(.K(4), .DEST_WIDTH(6), .FLIT_WIDTH(128)) bus_b ();

    butterfly_digit_router #(.K(2), .N(2), .STAGE(0), .DEST_WIDTH(6),
                             .FLIT_WIDTH(128), .FLIT_BUFFER_DEPTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));

    butterfly_digit_router #(.K(4), .N(3), .STAGE(1), .DEST_WIDTH(6),
                             .FLIT_WIDTH(128), .FLIT_BUFFER_DEPTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // downstream model: returns one credit the cycle after each received flit
    initial begin
        bus_a.credit_in = '0;
        forever begin
            @(posedge clk);
            #2;
            bus_a.credit_in = (auto_credit ? bus_a.send_out : 2'b00) | manual_credit;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input int i, input logic [127:0] d, input logic [5:0] dst, input logic tail);
        bus_a.send_in[i]    = 1'b1;
        bus_a.data_in[i]    = d;
        bus_a.dest_in[i]    = dst;
        bus_a.is_tail_in[i] = tail;
    endtask

    task automatic idle_a();
        bus_a.send_in    = '0;
        bus_a.data_in    = '0;
        bus_a.dest_in    = '0;
        bus_a.is_tail_in = '0;
    endtask

    task automatic do_reset();
        auto_credit   = 1'b0;
        manual_credit = 2'b00;
        idle_a();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [127:0] pat(input int base, input int j);
        return {32'(base), 64'h0123_4567_89AB_CDEF, 32'(j)};
    endfunction

    logic [127:0] exp_seq [6];
    logic         sent;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        auto_credit   = 1'b1;
        manual_credit = 2'b00;
        rst_n = 1'b0;
        idle_a();
        bus_b.send_in    = '0;
        bus_b.data_in    = '0;
        bus_b.dest_in    = '0;
        bus_b.is_tail_in = '0;
        bus_b.credit_in  = '0;
        tick();
        tick();

        // reset values
        check("rst_send_out",   128'(bus_a.send_out),    128'd0);
        check("rst_credit_out", 128'(bus_a.credit_out),  128'd0);
        check("rst_tail_out",   128'(bus_a.is_tail_out), 128'd0);
        check("rst_data_out1",  bus_a.data_out[1],       128'd0);
        check("rst_dest_out0",  128'(bus_a.dest_out[0]), 128'd0);
        check("rst_b_send_out", 128'(bus_b.send_out),    128'd0);
        rst_n = 1'b1;
        tick();

        // single-flit packet, input 0 -> output 1, two-cycle latency
        drive_a(0, pat(1, 0), 6'b000010, 1'b1);
        tick();
        idle_a();
        check("t1_no_early_send", 128'(bus_a.send_out), 128'd0);
        tick();
        check("t1_send_out",   128'(bus_a.send_out),    128'b10);
        check("t1_data_out",   bus_a.data_out[1],       pat(1, 0));
        check("t1_dest_out",   128'(bus_a.dest_out[1]), 128'b000010);
        check("t1_tail_out",   128'(bus_a.is_tail_out), 128'b10);
        check("t1_credit_out", 128'(bus_a.credit_out),  128'b01);
        tick();
        check("t1_send_clear",   128'(bus_a.send_out),   128'd0);
        check("t1_credit_clear", 128'(bus_a.credit_out), 128'd0);

        // K=4 stage 1: digit dest[3:2]=11 -> output 3
        bus_b.send_in[2] = 1'b1;
        bus_b.data_in[2] = pat(6, 0);
        bus_b.dest_in[2] = 6'b01_11_00;
        bus_b.is_tail_in[2] = 1'b1;
        tick();
        bus_b.send_in = '0;
        tick();
        check("t6_send_out",   128'(bus_b.send_out),    128'b1000);
        check("t6_data_out",   bus_b.data_out[3],       pat(6, 0));
        check("t6_dest_out",   128'(bus_b.dest_out[3]), 128'b011100);
        check("t6_credit_out", 128'(bus_b.credit_out),  128'b0100);
        tick();

        // two 3-flit packets contend for output 0: no interleaving
        for (int j = 0; j < 3; j++) begin
            exp_seq[j]     = pat(2, j);
            exp_seq[j + 3] = pat(3, j);
        end
        for (int c = 0; c < 8; c++) begin
            if (c < 3) begin
                drive_a(0, pat(2, c), 6'b000000, c == 2);
                drive_a(1, pat(3, c), 6'b000000, c == 2);
            end else begin
                idle_a();
            end
            tick();
            if (c >= 1 && c <= 6) begin
                check($sformatf("t2_send_c%0d", c), 128'(bus_a.send_out), 128'b01);
                check($sformatf("t2_data_c%0d", c), bus_a.data_out[0], exp_seq[c - 1]);
                check($sformatf("t2_tail_c%0d", c), 128'(bus_a.is_tail_out[0]),
                      128'(c == 3 || c == 6));
            end else begin
                check($sformatf("t2_idle_c%0d", c), 128'(bus_a.send_out), 128'd0);
            end
        end

        // pointer back at 0: input 0 wins the next tie
        drive_a(0, pat(4, 0), 6'b000000, 1'b1);
        drive_a(1, pat(4, 1), 6'b000000, 1'b1);
        tick();
        idle_a();
        tick();
        check("t2b_first_send", 128'(bus_a.send_out), 128'b01);
        check("t2b_first_data", bus_a.data_out[0],    pat(4, 0));
        tick();
        check("t2b_second_send", 128'(bus_a.send_out), 128'b01);
        check("t2b_second_data", bus_a.data_out[0],    pat(4, 1));
        tick();
        check("t2b_idle", 128'(bus_a.send_out), 128'd0);

        // credit starvation on output 1
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c < 6) drive_a(0, pat(5, c), 6'b000010, 1'b1);
            else       idle_a();
            tick();
            sent = (c >= 1 && c <= 4);
            check($sformatf("t3_send_c%0d", c), 128'(bus_a.send_out), sent ? 128'b10 : 128'd0);
            check($sformatf("t3_credit_out_c%0d", c), 128'(bus_a.credit_out),
                  sent ? 128'b01 : 128'd0);
            if (sent) check($sformatf("t3_data_c%0d", c), bus_a.data_out[1], pat(5, c - 1));
        end
        manual_credit = 2'b10;
        tick();
        manual_credit = 2'b00;
        check("t3_credit_send", 128'(bus_a.send_out), 128'b10);
        check("t3_credit_data", bus_a.data_out[1],    pat(5, 4));
        tick();
        check("t3_stall_again", 128'(bus_a.send_out), 128'd0);

        // body flit follows the latched route, ignoring its own digit
        do_reset();
        drive_a(0, pat(7, 0), 6'b110010, 1'b0);
        tick();
        drive_a(0, pat(7, 1), 6'b000001, 1'b1);
        tick();
        idle_a();
        check("t4_head_send", 128'(bus_a.send_out),    128'b10);
        check("t4_head_dest", 128'(bus_a.dest_out[1]), 128'b110010);
        tick();
        check("t4_body_send", 128'(bus_a.send_out),    128'b10);
        check("t4_body_data", bus_a.data_out[1],       pat(7, 1));
        check("t4_body_dest", 128'(bus_a.dest_out[1]), 128'b000001);
        check("t4_body_tail", 128'(bus_a.is_tail_out), 128'b10);
        tick();
        check("t4_idle", 128'(bus_a.send_out), 128'd0);

        // asynchronous reset in the middle of a packet
        drive_a(1, pat(8, 0), 6'b000010, 1'b0);
        tick();
        drive_a(1, pat(8, 1), 6'b000010, 1'b0);
        tick();
        check("t5_head_send", 128'(bus_a.send_out), 128'b10);
        idle_a();
        rst_n = 1'b0;
        #1;
        check("t5_async_send",   128'(bus_a.send_out),   128'd0);
        check("t5_async_credit", 128'(bus_a.credit_out), 128'd0);
        check("t5_async_data",   bus_a.data_out[1],      128'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        // counters restored to 4: four flits pass before the stall
        for (int c = 0; c < 8; c++) begin
            if (c < 5) drive_a(0, pat(9, c), 6'b000010, 1'b1);
            else       idle_a();
            tick();
            sent = (c >= 1 && c <= 4);
            check($sformatf("t5_send_c%0d", c), 128'(bus_a.send_out), sent ? 128'b10 : 128'd0);
            check($sformatf("t5_credit_out_c%0d", c), 128'(bus_a.credit_out),
                  sent ? 128'b01 : 128'd0);
            if (sent) check($sformatf("t5_data_c%0d", c), bus_a.data_out[1], pat(9, c - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
